// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the memory-side and decoder-side signals of the fetch stage.
//   The signal prefixes (o_/i_) are seen from the fetch stage.
//
//   Parameters:
//     ADDR_WIDTH      program counter / instruction memory address width
//
//   Signals:
//     o_Mem_Addr      instruction memory address (equals o_PC)
//     o_Mem_Req       memory read request
//     i_Mem_Ack       memory returns i_Mem_Data this cycle
//     i_Mem_Data      9-bit instruction word from memory
//     o_Instrucciones instruction register, to decoder
//     o_Valid         instruction register holds an unconsumed instruction
//     i_Ready         decoder accepts the instruction this cycle
//     i_Jump_Taken    redirect the PC on the current accept
//     i_Jump_Target   redirect address
//     o_PC            address of the instruction being fetched or held
//     o_Halted        core halted
//
//   Modports:
//     master  fetch stage side
//     slave   memory / decoder / jump unit side
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] o_Mem_Addr;
  logic                  o_Mem_Req;
  logic                  i_Mem_Ack;
  logic [8:0]            i_Mem_Data;
  logic [8:0]            o_Instrucciones;
  logic                  o_Valid;
  logic                  i_Ready;
  logic                  i_Jump_Taken;
  logic [ADDR_WIDTH-1:0] i_Jump_Target;
  logic [ADDR_WIDTH-1:0] o_PC;
  logic                  o_Halted;

  modport master (
    output o_Mem_Addr,
    output o_Mem_Req,
    input  i_Mem_Ack,
    input  i_Mem_Data,
    output o_Instrucciones,
    output o_Valid,
    input  i_Ready,
    input  i_Jump_Taken,
    input  i_Jump_Target,
    output o_PC,
    output o_Halted
  );

  modport slave (
    input  o_Mem_Addr,
    input  o_Mem_Req,
    output i_Mem_Ack,
    output i_Mem_Data,
    input  o_Instrucciones,
    input  o_Valid,
    output i_Ready,
    output i_Jump_Taken,
    output i_Jump_Target,
    input  o_PC,
    input  o_Halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage of the 9-bit microcontroller core. Holds the program counter,
//   requests words from instruction memory with a req/ack handshake, latches
//   each returned word into the instruction register and offers it to the
//   decoder with a valid/ready handshake. Each accepted instruction advances
//   the PC by one (modulo 2^ADDR_WIDTH) or loads the jump target.
//
//   Parameters:
//     ADDR_WIDTH  PC / memory address width (must match the interface)
//     RESET_ADDR  PC value after reset
//
//   Ports:
//     i_Clk       rising-edge clock
//     i_Rst       synchronous, active-high reset
//     bus         instruction_fetch_if.master (memory + decoder + jump signals)
//
//   Optional feature (macro FETCH_HALT_EN):
//     When defined, accepting the instruction 9'h1FF parks the stage in HALT
//     (no requests, o_Valid=0, o_Halted=1) until reset. When undefined,
//     9'h1FF is an ordinary instruction and o_Halted is tied to 0.
//
//   All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_ADDR = 0
) (
  input logic                 i_Clk,
  input logic                 i_Rst,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);

`ifdef FETCH_HALT_EN
  localparam logic [8:0] HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  mem_req;
  logic                  valid;
  logic [8:0]            instr;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] next_pc;

  // Decoder consumes the held instruction this cycle.
  assign handshake = valid && bus.i_Ready;

  // A jump target is taken verbatim; the increment wraps naturally at all-ones.
  assign next_pc = bus.i_Jump_Taken ? bus.i_Jump_Target : pc + ADDR_WIDTH'(1);

  // Fetch FSM. Every output is a register updated here, so the memory address
  // and PC change only on clock edges and the request is stable while waiting.
`ifdef FETCH_HALT_EN
  logic halted;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      mem_req <= 1'b0;
      valid   <= 1'b0;
      instr   <= 9'h000;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
        REQ: begin
          if (bus.i_Mem_Ack) begin
            instr   <= bus.i_Mem_Data;
            valid   <= 1'b1;
            mem_req <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            pc    <= next_pc;
            valid <= 1'b0;
            // The halt word still updates the PC but stops further fetching.
            if (instr == HALT_WORD) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          mem_req <= 1'b0;
          valid   <= 1'b0;
          halted  <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Halted = halted;
`else
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      mem_req <= 1'b0;
      valid   <= 1'b0;
      instr   <= 9'h000;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
        REQ: begin
          if (bus.i_Mem_Ack) begin
            instr   <= bus.i_Mem_Data;
            valid   <= 1'b1;
            mem_req <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            pc      <= next_pc;
            valid   <= 1'b0;
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Halted = 1'b0;
`endif

  assign bus.o_Mem_Addr      = pc;
  assign bus.o_PC            = pc;
  assign bus.o_Mem_Req       = mem_req;
  assign bus.o_Valid         = valid;
  assign bus.o_Instrucciones = instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch (ADDR_WIDTH=8, RESET_ADDR=0).
//   A transaction-level model (request outstanding / instruction held / halted
//   flags plus a PC) predicts every output each cycle; directed sections pin
//   the model with hand-computed values. Honours FETCH_HALT_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_if #(.ADDR_WIDTH(8)) bus ();

  instruction_fetch #(
    .ADDR_WIDTH(8),
    .RESET_ADDR(0)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Instruction memory contents and stimulus knobs.
  logic [8:0] mem [256];
  bit cfg_rst          = 1'b1;
  int cfg_ready_pct    = 100;
  int cfg_jump_pct     = 0;
  int cfg_target       = -1;
  int cfg_min_delay    = 0;
  int cfg_max_delay    = 0;
  int cfg_spurious_pct = 0;
  int wait_cnt         = 0;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model state.
  bit         m_known    = 1'b0;
  bit         m_starting = 1'b0;
  bit         m_req      = 1'b0;
  bit         m_valid    = 1'b0;
  bit         m_halted   = 1'b0;
  logic [7:0] m_pc       = 8'h00;
  logic [8:0] m_instr    = 9'h000;

  // Single comparison with a FAIL line on disagreement.
  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs: memory responder with a random latency,
  // optional spurious acks, random ready and jump requests.
  task automatic applyStimulus();
    bit ack;
    rst = cfg_rst;
    ack = 1'b0;
    if (bus.o_Mem_Req === 1'b1) begin
      if (wait_cnt == 0) begin
        ack = 1'b1;
        wait_cnt = $urandom_range(cfg_max_delay, cfg_min_delay);
      end else begin
        wait_cnt--;
      end
    end else if ($urandom_range(0, 99) < cfg_spurious_pct) begin
      ack = 1'b1;
    end
    if (cfg_rst) wait_cnt = $urandom_range(cfg_max_delay, cfg_min_delay);
    bus.i_Mem_Ack     = ack;
    bus.i_Mem_Data    = (ack && bus.o_Mem_Req === 1'b1) ? mem[bus.o_Mem_Addr] : 9'($urandom);
    bus.i_Ready       = ($urandom_range(0, 99) < cfg_ready_pct);
    bus.i_Jump_Taken  = ($urandom_range(0, 99) < cfg_jump_pct);
    bus.i_Jump_Target = (cfg_target < 0) ? 8'($urandom) : 8'(cfg_target);
  endtask

  // Advances the model by one clock edge from the inputs seen on that edge.
  task automatic updateModel();
    if (rst) begin
      m_known    = 1'b1;
      m_starting = 1'b1;
      m_req      = 1'b0;
      m_valid    = 1'b0;
      m_halted   = 1'b0;
      m_pc       = 8'h00;
      m_instr    = 9'h000;
    end else if (!m_known || m_halted) begin
      // nothing moves
    end else if (m_starting) begin
      m_starting = 1'b0;
      m_req      = 1'b1;
    end else if (m_req) begin
      if (bus.i_Mem_Ack) begin
        m_req   = 1'b0;
        m_valid = 1'b1;
        m_instr = mem[m_pc];
      end
    end else if (m_valid && bus.i_Ready) begin
      m_pc    = bus.i_Jump_Taken ? bus.i_Jump_Target : m_pc + 8'd1;
      m_valid = 1'b0;
      if (HALT_EN && m_instr == 9'h1FF) m_halted = 1'b1;
      else m_req = 1'b1;
    end
  endtask

  task automatic checkOutput();
    compare("o_Mem_Req",  {15'd0, bus.o_Mem_Req}, {15'd0, m_req});
    compare("o_Valid",    {15'd0, bus.o_Valid},   {15'd0, m_valid});
    compare("o_Halted",   {15'd0, bus.o_Halted},  {15'd0, m_halted});
    compare("o_PC",       {8'd0, bus.o_PC},       {8'd0, m_pc});
    compare("o_Mem_Addr", {8'd0, bus.o_Mem_Addr}, {8'd0, m_pc});
    compare("o_Instrucciones", {7'd0, bus.o_Instrucciones}, {7'd0, m_instr});
  endtask

  // Compare process: model steps on the edge, outputs are checked 1 unit later.
  always @(posedge clk) begin
    updateModel();
    #1;
    if (m_known) checkOutput();
  end

  // One full cycle; returns 2 units after the rising edge.
  task automatic step();
    @(negedge clk);
    applyStimulus();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    cfg_rst = 1'b1;
    step();
    step();
    cfg_rst = 1'b0;
  endtask

  // Runs with ready=1, no jumps, until the instruction at pc_val is held.
  task automatic waitHeld(input logic [7:0] pc_val);
    bit found;
    found = 1'b0;
    cfg_jump_pct = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.o_Valid === 1'b1 && bus.o_PC === pc_val) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL wait_held_%0h: timed out, o_PC=%0h", pc_val, bus.o_PC);
    end
  endtask

  // Accepts the held instruction with an optional jump.
  task automatic acceptWith(input bit jump, input logic [7:0] target);
    cfg_ready_pct = 100;
    cfg_jump_pct  = jump ? 100 : 0;
    cfg_target    = int'(target);
    step();
    cfg_jump_pct  = 0;
    cfg_target    = -1;
  endtask

  task automatic waitSignal(input string name, input bit want_req);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((want_req ? bus.o_Mem_Req : bus.o_Valid) === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: timed out", name);
    end
  endtask

  task automatic checkResetLiterals(input string tag);
    compare({tag, "_req"},   {15'd0, bus.o_Mem_Req}, 16'd0);
    compare({tag, "_valid"}, {15'd0, bus.o_Valid},   16'd0);
    compare({tag, "_pc"},    {8'd0, bus.o_PC},       16'd0);
    compare({tag, "_instr"}, {7'd0, bus.o_Instrucciones}, 16'd0);
  endtask

  initial begin
    bus.i_Mem_Ack     = 1'b0;
    bus.i_Mem_Data    = 9'h000;
    bus.i_Ready       = 1'b0;
    bus.i_Jump_Taken  = 1'b0;
    bus.i_Jump_Target = 8'h00;
    for (int n = 0; n < 256; n++) mem[n] = 9'(n + 'h040);

    // Zero-wait memory, ready held high.
    doReset();
    checkResetLiterals("reset");
    compare("reset_halted", {15'd0, bus.o_Halted}, 16'd0);
    step();
    compare("first_req",  {15'd0, bus.o_Mem_Req}, 16'd1);
    compare("first_addr", {8'd0, bus.o_Mem_Addr}, 16'h000);
    step();
    compare("first_valid", {15'd0, bus.o_Valid}, 16'd1);
    compare("first_instr", {7'd0, bus.o_Instrucciones}, 16'h040);
    step();
    compare("second_addr", {8'd0, bus.o_Mem_Addr}, 16'h001);
    compare("second_req",  {15'd0, bus.o_Mem_Req}, 16'd1);
    step();
    compare("second_instr", {7'd0, bus.o_Instrucciones}, 16'h041);
    for (int i = 0; i < 10; i++) step();

    // Memory with a fixed 3-cycle latency.
    cfg_min_delay = 3;
    cfg_max_delay = 3;
    for (int i = 0; i < 24; i++) step();

    // Decoder stalls for 4 cycles with an instruction held.
    cfg_min_delay = 0;
    cfg_max_delay = 0;
    cfg_ready_pct = 0;
    waitSignal("stall_valid", 1'b0);
    for (int i = 0; i < 4; i++) step();
    compare("stall_no_req", {15'd0, bus.o_Mem_Req}, 16'd0);
    cfg_ready_pct = 100;

    // Jump at PC=5, wrap at all-ones, jump beats wrap at all-ones.
    doReset();
    waitHeld(8'h05);
    acceptWith(1'b1, 8'h20);
    compare("jump_addr", {8'd0, bus.o_Mem_Addr}, 16'h020);
    waitHeld(8'h20);
    acceptWith(1'b1, 8'hFF);
    waitHeld(8'hFF);
    acceptWith(1'b0, 8'h00);
    compare("wrap_addr", {8'd0, bus.o_Mem_Addr}, 16'h000);
    waitHeld(8'h00);
    acceptWith(1'b1, 8'hFF);
    waitHeld(8'hFF);
    acceptWith(1'b1, 8'h10);
    compare("jump_at_ff", {8'd0, bus.o_Mem_Addr}, 16'h010);

    // Reset while a request is pending (ack may land on the reset edge).
    cfg_min_delay = 2;
    cfg_max_delay = 2;
    doReset();
    waitSignal("req_for_reset", 1'b1);
    step();
    cfg_rst = 1'b1;
    step();
    cfg_rst = 1'b0;
    checkResetLiterals("rst_in_req");
    for (int i = 0; i < 6; i++) step();

    // Reset while an instruction is held.
    cfg_min_delay = 0;
    cfg_max_delay = 0;
    cfg_ready_pct = 0;
    waitSignal("valid_for_reset", 1'b0);
    cfg_rst = 1'b1;
    step();
    cfg_rst = 1'b0;
    checkResetLiterals("rst_in_hold");
    cfg_ready_pct = 100;
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic with random contents, resets and spurious acks.
    for (int n = 0; n < 256; n++) mem[n] = 9'($urandom);
    for (int blk = 0; blk < 15; blk++) begin
      cfg_ready_pct    = $urandom_range(100, 30);
      cfg_jump_pct     = $urandom_range(40, 0);
      cfg_min_delay    = 0;
      cfg_max_delay    = $urandom_range(4, 0);
      cfg_spurious_pct = 20;
      for (int i = 0; i < 200; i++) begin
        cfg_rst = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    cfg_rst          = 1'b0;
    cfg_jump_pct     = 0;
    cfg_spurious_pct = 0;
    cfg_ready_pct    = 100;
    cfg_max_delay    = 0;

    // Halt word at address 3.
    for (int n = 0; n < 256; n++) mem[n] = 9'(n + 'h040);
    mem[3] = 9'h1FF;
    doReset();
    waitHeld(8'h03);
    acceptWith(1'b0, 8'h00);
    if (HALT_EN) begin
      compare("halted", {15'd0, bus.o_Halted}, 16'd1);
      compare("halt_pc", {8'd0, bus.o_PC}, 16'h004);
      for (int i = 0; i < 20; i++) begin
        step();
        compare("halt_no_req", {15'd0, bus.o_Mem_Req}, 16'd0);
      end
    end else begin
      compare("no_halt_req",  {15'd0, bus.o_Mem_Req}, 16'd1);
      compare("no_halt_addr", {8'd0, bus.o_Mem_Addr}, 16'h004);
      step();
      compare("no_halt_instr", {7'd0, bus.o_Instrucciones}, 16'h044);
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
